// File: rtl/chunk_packer.sv
// chunk_packer: packs D-bit samples into WORD_WIDTH-bit words and zero-pads words closed early by a frame end.
// Optional macro PACK_COUNT_EN adds m_lanes_out, the filled-lane count registered with each word.
module chunk_packer #(
  parameter int WORD_WIDTH = 128,
  parameter int D          = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [D-1:0]          s_data_in,
  input  logic                  s_valid_in,
  input  logic                  s_last_in,
  output logic                  s_ready_out,
  output logic [WORD_WIDTH-1:0] m_data_out,
  output logic                  m_valid_out,
  input  logic                  m_ready_in,
  output logic                  m_last_out
`ifdef PACK_COUNT_EN
  ,
  output logic [$clog2(WORD_WIDTH/D):0] m_lanes_out
`endif
);

  localparam int LANES = WORD_WIDTH / D;
  localparam int IDXW  = (LANES > 1) ? $clog2(LANES) : 1;

  logic [WORD_WIDTH-1:0] fill;
  logic [WORD_WIDTH-1:0] fill_next;
  logic [IDXW-1:0]       idx;
  logic                  pending;
  logic                  hold_last;
  logic                  accept;
  logic                  closing;
  logic                  slot_free;
  logic                  transfer;

  // A pending word blocks new samples until the output register drains.
  assign s_ready_out = rst_n_in && !pending;

  always_comb begin
    fill_next = fill;
    for (int k = 0; k < LANES; k++) begin
      if (idx == IDXW'(k)) fill_next[k*D +: D] = s_data_in;
    end
    accept    = s_valid_in && s_ready_out;
    closing   = accept && ((idx == IDXW'(LANES - 1)) || s_last_in);
    slot_free = !m_valid_out || m_ready_in;
    transfer  = (closing || pending) && slot_free;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fill        <= '0;
      idx         <= '0;
      pending     <= 1'b0;
      hold_last   <= 1'b0;
      m_data_out  <= '0;
      m_valid_out <= 1'b0;
      m_last_out  <= 1'b0;
    end else begin
      if (transfer) begin
        m_data_out  <= pending ? fill : fill_next;
        m_last_out  <= pending ? hold_last : s_last_in;
        m_valid_out <= 1'b1;
        fill        <= '0;
      end else begin
        if (m_valid_out && m_ready_in) m_valid_out <= 1'b0;
        if (accept) fill <= fill_next;
      end

      // A closed word that cannot move yet stays in the fill register.
      if (closing && !slot_free) begin
        pending   <= 1'b1;
        hold_last <= s_last_in;
      end else if (pending && slot_free) begin
        pending <= 1'b0;
      end

      if (accept) idx <= closing ? '0 : idx + 1'b1;
    end
  end

`ifdef PACK_COUNT_EN
  localparam int CNTW = $clog2(LANES) + 1;

  logic [CNTW-1:0] hold_lanes;
  logic [CNTW-1:0] close_lanes;

  assign close_lanes = CNTW'(idx) + 1'b1;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hold_lanes  <= '0;
      m_lanes_out <= '0;
    end else begin
      if (closing && !slot_free) hold_lanes <= close_lanes;
      if (transfer) m_lanes_out <= pending ? hold_lanes : close_lanes;
    end
  end
`endif

endmodule
